// File: rtl/lfm_chirp_ctrl.sv
// ---------------------------------------------------------------------------
// lfm_chirp_ctrl
//
// Sequencer for the LFM DDS datapath. It drives the frequency-tuning word
// (FTW) of the phase accumulator so that one configured DDS core emits a
// train of linear-chirp pulses separated by programmable gaps.
//
// Optional build macro:
//   LFM_TRIANGLE_EN  - each chirp is a symmetric up/down sweep: samples
//                      1..H add dftw, samples H+1..len_eff-1 subtract it,
//                      with H = len_eff >> 1. Undefined: sawtooth only.
//
// Parameters:
//   N_PHASE   phase accumulator / FTW width
//   CNT_W     width of the chirp-length and gap counters
//   NPULSE_W  width of the pulse-count and pulse-index fields
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset, priority over all inputs
//   cfg_ftw0    FTW on the first sample of every chirp
//   cfg_dftw    per-sample FTW increment (two's complement)
//   cfg_len     chirp length in samples (0 behaves as 1)
//   cfg_gap     idle samples after each chirp (0 = back-to-back chirps)
//   cfg_npulse  number of pulses (0 = run until abort)
//   start       single-cycle start request, honoured only when idle
//   abort       stop immediately, returns to idle without done
//   busy        high whenever a train is pending or running
//   ftw_out     FTW presented to the DDS accumulator
//   phase_clr   clears the DDS accumulator on sample 0 of each chirp
//   tx_en       high on chirp samples, gates the DDS output
//   pulse_idx   index of the current pulse, counting from 0
//   done        one-cycle strobe when a finite train completes
//
// Timing: start sampled at edge k is parked in start_q; the first chirp
// sample (tx_en, phase_clr, ftw_out = cfg_ftw0) is registered at edge k+1.
// All outputs except busy are registers.
// ---------------------------------------------------------------------------
module lfm_chirp_ctrl #(
    parameter int N_PHASE  = 32,
    parameter int CNT_W    = 24,
    parameter int NPULSE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PHASE-1:0]  cfg_ftw0,
    input  logic [N_PHASE-1:0]  cfg_dftw,
    input  logic [CNT_W-1:0]    cfg_len,
    input  logic [CNT_W-1:0]    cfg_gap,
    input  logic [NPULSE_W-1:0] cfg_npulse,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic [N_PHASE-1:0]  ftw_out,
    output logic                phase_clr,
    output logic                tx_en,
    output logic [NPULSE_W-1:0] pulse_idx,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [NPULSE_W-1:0] NP_ONE  = NPULSE_W'(1);

    // FSM and output registers
    state_t                state,   state_d;
    logic                  start_q, start_q_d;
    logic [CNT_W-1:0]      cnt,     cnt_d;
    logic [N_PHASE-1:0]    ftw_q,   ftw_d;
    logic                  pclr_q,  pclr_d;
    logic                  tx_q,    tx_d;
    logic [NPULSE_W-1:0]   idx_q,   idx_d;
    logic                  done_q,  done_d;

    // Configuration captured when start is accepted
    logic [N_PHASE-1:0]    ftw0_q;
    logic [N_PHASE-1:0]    dftw_q;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      gap_q;
    logic [NPULSE_W-1:0]   npulse_q;
`ifdef LFM_TRIANGLE_EN
    logic [CNT_W-1:0]      half_q;
`endif

    logic                  load_cfg;
    logic                  pulse_end;
    logic                  last_pulse;
    logic [CNT_W-1:0]      len_eff;

    assign len_eff    = (cfg_len == '0) ? CNT_ONE : cfg_len;
    // npulse_q == 0 never matches, which gives the continuous mode.
    assign last_pulse = (npulse_q != '0) && (idx_q == npulse_q - NP_ONE);

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d   = state;
        start_q_d = 1'b0;
        cnt_d     = cnt;
        ftw_d     = ftw_q;
        pclr_d    = 1'b0;
        tx_d      = tx_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        load_cfg  = 1'b0;
        pulse_end = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_q) begin
                    // First sample of the first chirp
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                    ftw_d   = ftw0_q;
                    pclr_d  = 1'b1;
                    tx_d    = 1'b1;
                end else if (start) begin
                    start_q_d = 1'b1;
                    load_cfg  = 1'b1;
                    idx_d     = '0;
                end
            end

            ST_SWEEP: begin
                if (cnt == len_q - CNT_ONE) begin
                    if (gap_q != '0) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                        ftw_d   = '0;
                        tx_d    = 1'b0;
                    end else begin
                        pulse_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_ONE;
`ifdef LFM_TRIANGLE_EN
                    // Moving from sample cnt to cnt+1: rise while cnt+1 <= H.
                    ftw_d = (cnt < half_q) ? ftw_q + dftw_q : ftw_q - dftw_q;
`else
                    ftw_d = ftw_q + dftw_q;
`endif
                end
            end

            ST_GAP: begin
                if (cnt == gap_q - CNT_ONE) begin
                    pulse_end = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ftw_d   = '0;
                tx_d    = 1'b0;
            end
        endcase

        // End of a pulse (sweep with no gap, or gap expiry): either the
        // train is complete or the next chirp starts without a bubble.
        if (pulse_end) begin
            if (last_pulse) begin
                state_d = ST_IDLE;
                ftw_d   = '0;
                tx_d    = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
                ftw_d   = ftw0_q;
                pclr_d  = 1'b1;
                tx_d    = 1'b1;
                idx_d   = idx_q + NP_ONE;
            end
        end

        // Abort overrides everything, including a start in the same cycle.
        // pulse_idx is left untouched so the aborted position stays visible.
        if (abort) begin
            state_d   = ST_IDLE;
            start_q_d = 1'b0;
            load_cfg  = 1'b0;
            cnt_d     = '0;
            ftw_d     = '0;
            pclr_d    = 1'b0;
            tx_d      = 1'b0;
            idx_d     = idx_q;
            done_d    = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            cnt     <= '0;
            ftw_q   <= '0;
            pclr_q  <= 1'b0;
            tx_q    <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            start_q <= start_q_d;
            cnt     <= cnt_d;
            ftw_q   <= ftw_d;
            pclr_q  <= pclr_d;
            tx_q    <= tx_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the configuration registers carry no reset: they are written on
    // every accepted start and only read while a train is running.
    always_ff @(posedge clk) begin
        if (load_cfg) begin
            ftw0_q   <= cfg_ftw0;
            dftw_q   <= cfg_dftw;
            len_q    <= len_eff;
            gap_q    <= cfg_gap;
            npulse_q <= cfg_npulse;
`ifdef LFM_TRIANGLE_EN
            half_q   <= len_eff >> 1;
`endif
        end
    end

    assign busy      = (state != ST_IDLE) || start_q;
    assign ftw_out   = ftw_q;
    assign phase_clr = pclr_q;
    assign tx_en     = tx_q;
    assign pulse_idx = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lfm_chirp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfm_chirp_ctrl
//
// Self-checking bench for lfm_chirp_ctrl. Expected chirp samples
// (ftw, phase_clr, pulse_idx) are queued when a train is launched and
// popped by a monitor on every tx_en cycle. Each scenario task also records
// per-cycle tx_en/done/busy bit vectors relative to the start edge and
// compares them with hand-derived patterns. A second instance with
// NPULSE_W=2 covers pulse-index wrap-around in continuous mode.
// ---------------------------------------------------------------------------
module tb_lfm_chirp_ctrl;

    localparam int N_PHASE  = 32;
    localparam int CNT_W    = 24;
    localparam int NPULSE_W = 16;
    localparam int NPW_S    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N_PHASE-1:0]  cfg_ftw0   = '0;
    logic [N_PHASE-1:0]  cfg_dftw   = '0;
    logic [CNT_W-1:0]    cfg_len    = '0;
    logic [CNT_W-1:0]    cfg_gap    = '0;
    logic [NPULSE_W-1:0] cfg_npulse = '0;
    logic [NPW_S-1:0]    npulse_s   = 2'd1;
    logic                start      = 1'b0;
    logic                abort      = 1'b0;

    logic                busy, phase_clr, tx_en, done;
    logic [N_PHASE-1:0]  ftw_out;
    logic [NPULSE_W-1:0] pulse_idx;

    logic                busy_s, phase_clr_s, tx_en_s, done_s;
    logic [N_PHASE-1:0]  ftw_out_s;
    logic [NPW_S-1:0]    pulse_idx_s;

    lfm_chirp_ctrl #(.N_PHASE(N_PHASE), .CNT_W(CNT_W), .NPULSE_W(NPULSE_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_ftw0(cfg_ftw0), .cfg_dftw(cfg_dftw), .cfg_len(cfg_len),
        .cfg_gap(cfg_gap), .cfg_npulse(cfg_npulse),
        .start(start), .abort(abort),
        .busy(busy), .ftw_out(ftw_out), .phase_clr(phase_clr),
        .tx_en(tx_en), .pulse_idx(pulse_idx), .done(done)
    );

    lfm_chirp_ctrl #(.N_PHASE(N_PHASE), .CNT_W(CNT_W), .NPULSE_W(NPW_S)) dut_s (
        .clk(clk), .rst(rst),
        .cfg_ftw0(cfg_ftw0), .cfg_dftw(cfg_dftw), .cfg_len(cfg_len),
        .cfg_gap(cfg_gap), .cfg_npulse(npulse_s),
        .start(start), .abort(abort),
        .busy(busy_s), .ftw_out(ftw_out_s), .phase_clr(phase_clr_s),
        .tx_en(tx_en_s), .pulse_idx(pulse_idx_s), .done(done_s)
    );

    typedef struct packed {
        logic [N_PHASE-1:0]  ftw;
        logic                pclr;
        logic [NPULSE_W-1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Scoreboard monitor: every chirp sample must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (tx_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_sample got ftw=%h pclr=%b idx=%0d expected no sample",
                             ftw_out, phase_clr, pulse_idx);
                end else begin
                    e = sb.pop_front();
                    if ({ftw_out, phase_clr, pulse_idx} !== e) begin
                        errors++;
                        $display("FAIL sb_sample got ftw=%h pclr=%b idx=%0d expected ftw=%h pclr=%b idx=%0d",
                                 ftw_out, phase_clr, pulse_idx, e.ftw, e.pclr, e.idx);
                    end
                end
            end else if (phase_clr) begin
                checks++;
                errors++;
                $display("FAIL pclr_without_tx got phase_clr=1 expected 0");
            end
        end
    end

    // Reference FTW of sample s in a chirp of len_eff samples.
    function automatic logic [N_PHASE-1:0] model_ftw(input logic [N_PHASE-1:0] f0,
                                                     input logic [N_PHASE-1:0] d,
                                                     input int len_eff, input int s);
        logic [N_PHASE-1:0] f;
        f = f0;
        for (int i = 1; i <= s; i++) begin
`ifdef LFM_TRIANGLE_EN
            if (i <= len_eff / 2) f = f + d;
            else                  f = f - d;
`else
            f = f + d;
`endif
        end
        return f;
    endfunction

    task automatic push_pulses(input int first_idx, input int count, input int len_eff);
        exp_t e;
        for (int p = 0; p < count; p++) begin
            for (int s = 0; s < len_eff; s++) begin
                e.ftw  = model_ftw(cfg_ftw0, cfg_dftw, len_eff, s);
                e.pclr = (s == 0);
                e.idx  = NPULSE_W'(first_idx + p);
                sb.push_back(e);
            end
        end
    endtask

    task automatic push_ftw(input logic [N_PHASE-1:0] f, input bit pclr, input int idx);
        exp_t e;
        e.ftw  = f;
        e.pclr = pclr;
        e.idx  = NPULSE_W'(idx);
        sb.push_back(e);
    endtask

    // Launch a start (optionally with abort) at a negedge, then record
    // n_cyc cycles; bit n holds the value after start edge k plus n.
    // inj_* pulse start/abort/rst for one cycle after sample n.
    task automatic run_trace(input bit with_abort, input int n_cyc,
                             input int inj_start, input int inj_abort, input int inj_rst,
                             output logic [63:0] tx_v, output logic [63:0] done_v,
                             output logic [63:0] busy_v);
        tx_v = '0; done_v = '0; busy_v = '0;
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        for (int n = 0; n < n_cyc; n++) begin
            @(negedge clk);
            tx_v[n]   = tx_en;
            done_v[n] = done;
            busy_v[n] = busy;
            start = (n == inj_start);
            abort = (n == inj_abort);
            rst   = (n == inj_rst);
            if (n == inj_start) begin
                cfg_ftw0   = 32'hDEAD0000;
                cfg_len    = 24'd7;
                cfg_npulse = 16'd9;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_trace(input string name, input logic [63:0] tx_v, input logic [63:0] done_v,
                               input logic [63:0] busy_v, input logic [63:0] tx_e,
                               input logic [63:0] done_e, input logic [63:0] busy_e);
        checks++;
        if (tx_v !== tx_e) begin
            errors++;
            $display("FAIL %s_tx got %h expected %h", name, tx_v, tx_e);
        end
        checks++;
        if (done_v !== done_e) begin
            errors++;
            $display("FAIL %s_done got %h expected %h", name, done_v, done_e);
        end
        checks++;
        if (busy_v !== busy_e) begin
            errors++;
            $display("FAIL %s_busy got %h expected %h", name, busy_v, busy_e);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left got %0d samples pending expected 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, tx_en, phase_clr, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 0000", {busy, tx_en, phase_clr, done});
        end
        checks++;
        if (ftw_out !== '0 || pulse_idx !== '0) begin
            errors++;
            $display("FAIL reset_words got ftw=%h idx=%0d expected 0", ftw_out, pulse_idx);
        end
        checks++;
        if ({busy_s, tx_en_s, phase_clr_s, done_s, ftw_out_s, pulse_idx_s} !== '0) begin
            errors++;
            $display("FAIL reset_small got nonzero output expected 0");
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h1000; cfg_dftw = 32'h10; cfg_len = 24'd4; cfg_gap = 24'd2; cfg_npulse = 16'd1;
        push_ftw(32'h1000, 1'b1, 0);
        push_ftw(32'h1010, 1'b0, 0);
        push_ftw(32'h1020, 1'b0, 0);
`ifdef LFM_TRIANGLE_EN
        push_ftw(32'h1010, 1'b0, 0);
`else
        push_ftw(32'h1030, 1'b0, 0);
`endif
        run_trace(1'b0, 10, -1, -1, -1, tv, dv, bv);
        check_trace("basic", tv, dv, bv, 64'h1E, 64'h80, 64'h7F);
    endtask

    task automatic test_train();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h2000; cfg_dftw = 32'h100; cfg_len = 24'd3; cfg_gap = 24'd0; cfg_npulse = 16'd3;
        push_pulses(0, 3, 3);
        run_trace(1'b0, 12, -1, -1, -1, tv, dv, bv);
        check_trace("train", tv, dv, bv, 64'h3FE, 64'h400, 64'h3FF);
        checks++;
        if (pulse_idx !== 16'd2) begin
            errors++;
            $display("FAIL train_idx_hold got %0d expected 2", pulse_idx);
        end
    endtask

    task automatic test_collision();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h3000; cfg_dftw = 32'h1; cfg_len = 24'd2; cfg_gap = 24'd0; cfg_npulse = 16'd1;
        run_trace(1'b1, 6, -1, -1, -1, tv, dv, bv);
        check_trace("collision", tv, dv, bv, 64'h0, 64'h0, 64'h0);
        checks++;
        if (pulse_idx !== 16'd2) begin
            errors++;
            $display("FAIL collision_idx got %0d expected 2", pulse_idx);
        end
    endtask

    task automatic test_wrap_neg();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h8; cfg_dftw = 32'hFFFFFFFC; cfg_len = 24'd4; cfg_gap = 24'd0; cfg_npulse = 16'd1;
        push_ftw(32'h8, 1'b1, 0);
        push_ftw(32'h4, 1'b0, 0);
        push_ftw(32'h0, 1'b0, 0);
`ifdef LFM_TRIANGLE_EN
        push_ftw(32'h4, 1'b0, 0);
`else
        push_ftw(32'hFFFFFFFC, 1'b0, 0);
`endif
        run_trace(1'b0, 8, -1, -1, -1, tv, dv, bv);
        check_trace("wrap_neg", tv, dv, bv, 64'h1E, 64'h20, 64'h1F);
    endtask

    task automatic test_abort_gap();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h4000; cfg_dftw = 32'h4; cfg_len = 24'd2; cfg_gap = 24'd3; cfg_npulse = 16'd5;
        push_pulses(0, 2, 2);
        // abort raised in the first gap cycle of pulse 1, taken at edge k+9
        run_trace(1'b0, 30, -1, 8, -1, tv, dv, bv);
        check_trace("abort_gap", tv, dv, bv, 64'hC6, 64'h0, 64'h1FF);
        checks++;
        if (ftw_out !== '0 || phase_clr !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs got ftw=%h pclr=%b expected 0", ftw_out, phase_clr);
        end
    endtask

    task automatic test_start_busy();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h5000; cfg_dftw = 32'h20; cfg_len = 24'd2; cfg_gap = 24'd1; cfg_npulse = 16'd2;
        push_pulses(0, 2, 2);
        // second start (with new cfg) during pulse 0 must be ignored
        run_trace(1'b0, 10, 2, -1, -1, tv, dv, bv);
        check_trace("start_busy", tv, dv, bv, 64'h36, 64'h80, 64'h7F);
    endtask

    task automatic test_len0();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h6000; cfg_dftw = 32'h1; cfg_len = 24'd0; cfg_gap = 24'd0; cfg_npulse = 16'd2;
        push_ftw(32'h6000, 1'b1, 0);
        push_ftw(32'h6000, 1'b1, 1);
        run_trace(1'b0, 6, -1, -1, -1, tv, dv, bv);
        check_trace("len0", tv, dv, bv, 64'h6, 64'h8, 64'h7);
    endtask

    task automatic test_reset_mid();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h55; cfg_dftw = 32'h1; cfg_len = 24'd2; cfg_gap = 24'd0; cfg_npulse = 16'd3;
        push_ftw(32'h55, 1'b1, 0);
        push_ftw(32'h56, 1'b0, 0);
        push_ftw(32'h55, 1'b1, 1);
        run_trace(1'b0, 6, -1, -1, 3, tv, dv, bv);
        check_trace("reset_mid", tv, dv, bv, 64'hE, 64'h0, 64'hF);
        checks++;
        if (ftw_out !== '0 || pulse_idx !== '0 || phase_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_words got ftw=%h idx=%0d pclr=%b expected 0",
                     ftw_out, pulse_idx, phase_clr);
        end
    endtask

    task automatic test_idx_wrap();
        int done_cnt;
        mon_en = 1'b0;
        done_cnt = 0;
        cfg_ftw0 = 32'h7; cfg_dftw = 32'h1; cfg_len = 24'd1; cfg_gap = 24'd0;
        cfg_npulse = 16'd0; npulse_s = 2'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            checks++;
            if (tx_en_s !== 1'b1 || pulse_idx_s !== NPW_S'(n - 1)) begin
                errors++;
                $display("FAIL idx_wrap_sample%0d got tx=%b idx=%0d expected tx=1 idx=%0d",
                         n, tx_en_s, pulse_idx_s, (n - 1) % 4);
            end
            if (done_s) done_cnt++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL idx_wrap_done got %0d strobes expected 0", done_cnt);
        end
        checks++;
        if ({busy_s, tx_en_s, busy, tx_en} !== 4'b0) begin
            errors++;
            $display("FAIL idx_wrap_abort got %b expected 0000", {busy_s, tx_en_s, busy, tx_en});
        end
        npulse_s = 2'd1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

`ifdef LFM_TRIANGLE_EN
    task automatic test_triangle();
        logic [63:0] tv, dv, bv;
        cfg_ftw0 = 32'h0; cfg_dftw = 32'h1; cfg_len = 24'd6; cfg_gap = 24'd0; cfg_npulse = 16'd1;
        push_ftw(32'd0, 1'b1, 0);
        push_ftw(32'd1, 1'b0, 0);
        push_ftw(32'd2, 1'b0, 0);
        push_ftw(32'd3, 1'b0, 0);
        push_ftw(32'd2, 1'b0, 0);
        push_ftw(32'd1, 1'b0, 0);
        run_trace(1'b0, 10, -1, -1, -1, tv, dv, bv);
        check_trace("triangle", tv, dv, bv, 64'h7E, 64'h80, 64'h7F);
    endtask
`endif

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_basic();
        test_train();
        test_collision();
        test_wrap_neg();
        test_abort_gap();
        test_start_busy();
        test_len0();
        test_reset_mid();
        test_idx_wrap();
`ifdef LFM_TRIANGLE_EN
        test_triangle();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
